data_sram_resp: RTL and testbench

Responder side of the core's data SRAM interface: accepts the `data_sram_en/we/addr/wdata` requests issued by the EXE stage and returns `data_sram_rdata` to the MEM stage one cycle later. It combines a byte-writable synchronous RAM with a small memory-mapped register window containing LEDs, a free-running timer and a scratch register. It sits outside `mycpu_top` in the SoC/testbench and lets the pipeline run full load/store programs with a fixed 1-cycle read latency.

---
 rtl/data_sram_resp_if.sv | 32 +++
 rtl/data_sram_resp.sv | 114 +++++++++++
 tb/tb_data_sram_resp.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/data_sram_resp_if.sv
// rtl/data_sram_resp_if.sv - data SRAM request/response bus between pipeline and responder
//
// Signals:
//   data_sram_en    - access request this cycle
//   data_sram_we    - per-byte write enables, 0 means read
//   data_sram_addr  - byte address, bits [1:0] ignored by the responder
//   data_sram_wdata - lane-aligned write data
//   data_sram_rdata - read data for the access sampled on the previous edge
// Modports: master (requester), slave (responder).
interface data_sram_resp_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_en,
        output data_sram_we,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_en,
        input  data_sram_we,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata
    );
endinterface

// File: rtl/data_sram_resp.sv
// rtl/data_sram_resp.sv - data SRAM responder: byte-writable RAM plus LED/TIMER/SCRATCH window
//
// Ports:
//   clk   - sole clock, rising edge
//   reset - asynchronous, active-high
//   bus   - data_sram_resp_if.slave request/response bus, 1-cycle read latency
//   led   - low 16 bits of the LED register
//   timer - free-running timer value
// Register window (selected when addr[31:16] == MMIO_BASE[31:16]):
//   +0x0 LED, +0x4 TIMER, +0x8 SCRATCH, other offsets read 0 and ignore writes.
module data_sram_resp #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] MMIO_BASE  = 32'hbfaf_0000
) (
    input  logic             clk,
    input  logic             reset,
    data_sram_resp_if.slave  bus,
    output logic [15:0]      led,
    output logic [31:0]      timer
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] mem [DEPTH];

    logic [31:0] led_reg;
    logic [31:0] timer_reg;
    logic [31:0] scratch_reg;
    logic [31:0] rdata_reg;

    logic                  is_mmio;
    logic                  is_write;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic [13:0]           mmio_word;
    logic                  sel_led;
    logic                  sel_timer;
    logic                  sel_scratch;
    logic [31:0]           wmask;
    logic [31:0]           mmio_rd;
    logic [31:0]           ram_rd;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^bus.data_sram_addr[1:0];

    // Decode of the request presented this cycle.
    assign is_mmio     = (bus.data_sram_addr[31:16] == MMIO_BASE[31:16]);
    assign is_write    = bus.data_sram_en && (bus.data_sram_we != 4'b0000);
    assign ram_idx     = bus.data_sram_addr[ADDR_WIDTH+1:2];
    assign mmio_word   = bus.data_sram_addr[15:2];
    assign sel_led     = is_mmio && (mmio_word == 14'd0);
    assign sel_timer   = is_mmio && (mmio_word == 14'd1);
    assign sel_scratch = is_mmio && (mmio_word == 14'd2);

    // Byte-enable mask: every writable word merges new and old data per lane.
    assign wmask = {{8{bus.data_sram_we[3]}}, {8{bus.data_sram_we[2]}},
                    {8{bus.data_sram_we[1]}}, {8{bus.data_sram_we[0]}}};

    always_comb begin
        mmio_rd = 32'h0;
        if (sel_led) begin
            mmio_rd = led_reg;
        end else if (sel_timer) begin
            mmio_rd = timer_reg;
        end else if (sel_scratch) begin
            mmio_rd = scratch_reg;
        end
    end

    assign ram_rd = mem[ram_idx];

    // RAM array: no reset so contents survive a mid-stream reset.
    always_ff @(posedge clk) begin
        if (is_write && !is_mmio) begin
            mem[ram_idx] <= (mem[ram_idx] & ~wmask) | (bus.data_sram_wdata & wmask);
        end
    end

    // Read-first: rdata captures the pre-edge value even on a write access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_reg <= 32'h0;
        end else if (bus.data_sram_en) begin
            rdata_reg <= is_mmio ? mmio_rd : ram_rd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_reg     <= 32'h0;
            scratch_reg <= 32'h0;
        end else begin
            if (is_write && sel_led) begin
                led_reg <= (led_reg & ~wmask) | (bus.data_sram_wdata & wmask);
            end
            if (is_write && sel_scratch) begin
                scratch_reg <= (scratch_reg & ~wmask) | (bus.data_sram_wdata & wmask);
            end
        end
    end

    // A TIMER write replaces that edge's increment; counting resumes next edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_reg <= 32'h0;
        end else if (is_write && sel_timer) begin
            timer_reg <= (timer_reg & ~wmask) | (bus.data_sram_wdata & wmask);
        end else begin
            timer_reg <= timer_reg + 32'd1;
        end
    end

    assign bus.data_sram_rdata = rdata_reg;
    assign led                 = led_reg[15:0];
    assign timer               = timer_reg;
endmodule

// File: tb/tb_data_sram_resp.sv
// tb/tb_data_sram_resp.sv - self-checking bench for data_sram_resp
module tb_data_sram_resp;
    localparam logic [31:0] BASE = 32'hbfaf_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] led;
    logic [31:0] timer;

    int total = 0;
    int bad   = 0;

    data_sram_resp_if bus();

    data_sram_resp #(.ADDR_WIDTH(12), .MMIO_BASE(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .led   (led),
        .timer (timer)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_ram [int];
    logic [31:0] m_led, m_timer, m_scratch, m_rdata;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  we);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = we[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return r;
    endfunction

    task automatic model_reset();
        m_led = 0; m_timer = 0; m_scratch = 0; m_rdata = 0;
    endtask

    // Presents one request, lets one edge pass, advances the model, lands 1 ns after the edge.
    task automatic drive(input logic en, input logic [3:0] we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int          key;
        int          off;
        logic [31:0] old_v;
        logic        timer_wr;
        bus.data_sram_en    = en;
        bus.data_sram_we    = we;
        bus.data_sram_addr  = addr;
        bus.data_sram_wdata = wdata;
        @(posedge clk);
        timer_wr = 1'b0;
        old_v    = 0;
        if (en) begin
            if (addr[31:16] == BASE[31:16]) begin
                off = int'(addr[15:0]) / 4;
                case (off)
                    0: m_rdata = m_led;
                    1: m_rdata = m_timer;
                    2: m_rdata = m_scratch;
                    default: m_rdata = 0;
                endcase
                if (we != 0) begin
                    case (off)
                        0: m_led     = lane_merge(m_led, wdata, we);
                        1: begin old_v = lane_merge(m_timer, wdata, we); timer_wr = 1'b1; end
                        2: m_scratch = lane_merge(m_scratch, wdata, we);
                        default: ;
                    endcase
                end
            end else begin
                key     = int'(addr % 32'h4000) / 4;
                m_rdata = m_ram.exists(key) ? m_ram[key] : 32'h0;
                if (we != 0) begin
                    m_ram[key] = lane_merge(m_ram.exists(key) ? m_ram[key] : 32'h0, wdata, we);
                end
            end
        end
        m_timer = timer_wr ? old_v : m_timer + 1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.data_sram_en = 0; bus.data_sram_we = 0;
        bus.data_sram_addr = 0; bus.data_sram_wdata = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.data_sram_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", bus.data_sram_rdata); end
        total++; if (led !== 16'h0) begin bad++; $display("FAIL reset_led got=%h exp=0", led); end
        total++; if (timer !== 32'h0) begin bad++; $display("FAIL reset_timer got=%h exp=0", timer); end
        #2 reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            drive(0, 0, 0, 0);
            total++; if (timer !== 32'(i)) begin bad++; $display("FAIL reset_timer_count got=%h exp=%h", timer, i); end
        end
    endtask

    task automatic test_ram_lanes();
        drive(1, 4'hf, 32'h1000, 32'h1122_3344);
        drive(1, 4'h0, 32'h1000, 0);
        total++; if (bus.data_sram_rdata !== 32'h1122_3344) begin bad++; $display("FAIL ram_full got=%h exp=11223344", bus.data_sram_rdata); end
        drive(1, 4'b0010, 32'h1000, 32'h0000_AA00);
        total++; if (bus.data_sram_rdata !== 32'h1122_3344) begin bad++; $display("FAIL ram_partial_old got=%h exp=11223344", bus.data_sram_rdata); end
        drive(1, 4'h0, 32'h1000, 0);
        total++; if (bus.data_sram_rdata !== 32'h1122_AA44) begin bad++; $display("FAIL ram_lane got=%h exp=1122aa44", bus.data_sram_rdata); end
    endtask

    task automatic test_read_first();
        drive(1, 4'hf, 32'h2000, 32'h5);
        drive(1, 4'hf, 32'h2000, 32'h9);
        total++; if (bus.data_sram_rdata !== 32'h5) begin bad++; $display("FAIL read_first got=%h exp=5", bus.data_sram_rdata); end
        drive(1, 4'h0, 32'h2000, 0);
        total++; if (bus.data_sram_rdata !== 32'h9) begin bad++; $display("FAIL store_load got=%h exp=9", bus.data_sram_rdata); end
    endtask

    task automatic test_alias_decode();
        drive(1, 4'hf, 32'h0000_0010, 32'hCAFE);
        drive(1, 4'h0, 32'h0000_4010, 0);
        total++; if (bus.data_sram_rdata !== 32'hCAFE) begin bad++; $display("FAIL alias got=%h exp=cafe", bus.data_sram_rdata); end
        drive(1, 4'h0, BASE + 32'hC, 0);
        total++; if (bus.data_sram_rdata !== 32'h0) begin bad++; $display("FAIL hole_read got=%h exp=0", bus.data_sram_rdata); end
        drive(1, 4'hf, BASE + 32'hC, 32'hFFFF_FFFF);
        drive(1, 4'h0, BASE + 32'hC, 0);
        total++; if (bus.data_sram_rdata !== 32'h0) begin bad++; $display("FAIL hole_write got=%h exp=0", bus.data_sram_rdata); end
    endtask

    task automatic test_mmio_regs();
        drive(1, 4'hf, BASE, 32'h0001_00FF);
        total++; if (led !== 16'h00FF) begin bad++; $display("FAIL led_out got=%h exp=00ff", led); end
        drive(1, 4'hf, BASE + 32'h8, 32'hDEAD_BEEF);
        drive(1, 4'h0, BASE + 32'h8, 0);
        total++; if (bus.data_sram_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL scratch got=%h exp=deadbeef", bus.data_sram_rdata); end
        drive(1, 4'h0, BASE, 0);
        total++; if (bus.data_sram_rdata !== 32'h0001_00FF) begin bad++; $display("FAIL led_read got=%h exp=000100ff", bus.data_sram_rdata); end
    endtask

    task automatic test_timer();
        drive(1, 4'hf, BASE + 32'h4, 32'hFFFF_FFFE);
        total++; if (timer !== 32'hFFFF_FFFE) begin bad++; $display("FAIL timer_wr got=%h exp=fffffffe", timer); end
        drive(0, 0, 0, 0);
        total++; if (timer !== 32'hFFFF_FFFF) begin bad++; $display("FAIL timer_max got=%h exp=ffffffff", timer); end
        drive(0, 0, 0, 0);
        total++; if (timer !== 32'h0) begin bad++; $display("FAIL timer_wrap got=%h exp=0", timer); end
        drive(1, 4'hf, BASE + 32'h4, 32'hFF);
        drive(0, 0, 0, 0);
        drive(1, 4'b0001, BASE + 32'h4, 32'h7);
        total++; if (timer !== 32'h107) begin bad++; $display("FAIL timer_lane got=%h exp=107", timer); end
        drive(1, 4'h0, BASE + 32'h4, 0);
        total++; if (bus.data_sram_rdata !== 32'h107) begin bad++; $display("FAIL timer_read got=%h exp=107", bus.data_sram_rdata); end
        total++; if (timer !== 32'h108) begin bad++; $display("FAIL timer_after_read got=%h exp=108", timer); end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 3; i++) begin
            drive(0, 4'hf, 32'h2000, 32'h1234_5678);
            total++; if (bus.data_sram_rdata !== 32'h107) begin bad++; $display("FAIL idle_hold got=%h exp=107", bus.data_sram_rdata); end
        end
        drive(1, 4'h0, 32'h2000, 0);
        total++; if (bus.data_sram_rdata !== 32'h9) begin bad++; $display("FAIL idle_nowrite got=%h exp=9", bus.data_sram_rdata); end
    endtask

    task automatic test_random();
        logic [31:0] pool [10];
        logic [31:0] a;
        logic [3:0]  we;
        pool = '{32'h100, 32'h4100, 32'h104, 32'h3ffc, 32'h200, 32'h2004,
                 BASE, BASE + 32'h4, BASE + 32'h8, BASE + 32'h10};
        for (int i = 0; i < 6; i++) drive(1, 4'hf, pool[i], $urandom);
        for (int i = 0; i < 300; i++) begin
            a  = pool[$urandom_range(9, 0)];
            we = ($urandom_range(1, 0) == 1) ? 4'($urandom) : 4'h0;
            drive(1'($urandom_range(3, 0) != 0), we, a, $urandom);
            total++; if (bus.data_sram_rdata !== m_rdata) begin bad++; $display("FAIL rand_rdata cyc=%0d got=%h exp=%h", i, bus.data_sram_rdata, m_rdata); end
            total++; if (led !== m_led[15:0]) begin bad++; $display("FAIL rand_led cyc=%0d got=%h exp=%h", i, led, m_led[15:0]); end
            total++; if (timer !== m_timer) begin bad++; $display("FAIL rand_timer cyc=%0d got=%h exp=%h", i, timer, m_timer); end
        end
    endtask

    task automatic test_reset_midstream();
        drive(1, 4'hf, BASE, 32'hFFFF_1234);
        drive(1, 4'h0, 32'h1000, 0);
        total++; if (bus.data_sram_rdata !== 32'h1122_AA44) begin bad++; $display("FAIL pre_reset got=%h exp=1122aa44", bus.data_sram_rdata); end
        #2 reset = 1'b1;
        model_reset();
        #1;
        total++; if (bus.data_sram_rdata !== 32'h0) begin bad++; $display("FAIL mid_reset_rdata got=%h exp=0", bus.data_sram_rdata); end
        total++; if (led !== 16'h0) begin bad++; $display("FAIL mid_reset_led got=%h exp=0", led); end
        total++; if (timer !== 32'h0) begin bad++; $display("FAIL mid_reset_timer got=%h exp=0", timer); end
        #1 reset = 1'b0;
        drive(1, 4'h0, 32'h1000, 0);
        total++; if (bus.data_sram_rdata !== 32'h1122_AA44) begin bad++; $display("FAIL ram_kept got=%h exp=1122aa44", bus.data_sram_rdata); end
        total++; if (timer !== 32'h1) begin bad++; $display("FAIL post_reset_timer got=%h exp=1", timer); end
        drive(1, 4'h0, BASE + 32'h8, 0);
        total++; if (bus.data_sram_rdata !== 32'h0) begin bad++; $display("FAIL scratch_cleared got=%h exp=0", bus.data_sram_rdata); end
    endtask

    initial begin
        test_reset();
        test_ram_lanes();
        test_read_first();
        test_alias_decode();
        test_mmio_regs();
        test_timer();
        test_idle();
        test_random();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
